// File: rtl/uart_frame_sched.sv
// Round-robin transmit scheduler feeding an 8N1 UART transmitter with paced HEADER/ID/payload byte frames.
// Optional build macro UART_FRAME_CHKSUM_EN appends a mod-256 checksum byte (ID + payload bytes).
module uart_frame_sched #(
  parameter int         UART_BPS    = 9600,
  parameter int         CLK_FREQ    = 50_000_000,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         BYTE_PERIOD = 11 * (CLK_FREQ / UART_BPS)
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack1,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  pi_data,
  output logic        pi_flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

`ifdef UART_FRAME_CHKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  // Mid-frame bytes leave WAIT one cycle early so SEND lands the next strobe exactly BYTE_PERIOD later;
  // the last byte waits one more cycle so frame_done itself lands BYTE_PERIOD after the final strobe.
  localparam logic [19:0] GAP_TC = 20'(BYTE_PERIOD - 2);
  localparam logic [19:0] END_TC = 20'(BYTE_PERIOD - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_idx;
  logic [19:0] r_cnt;
  logic        r_last_grant;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_busy;
  logic        r_done;
  logic        r_flag;
  logic [7:0]  r_pi_data;
  logic        r_id;
  logic [31:0] r_payload;

  logic        w_gnt_vld;
  logic        w_gnt_ch;
  logic [7:0]  w_byte;

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign pi_data    = r_pi_data;
  assign pi_flag    = r_flag;

  // Both requesting: serve the channel that did not win last time.
  assign w_gnt_vld = req0 | req1;
  assign w_gnt_ch  = (req0 & req1) ? ~r_last_grant : req1;

`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0] w_chksum;
  assign w_chksum = {7'd0, r_id} + r_payload[31:24] + r_payload[23:16]
                  + r_payload[15:8] + r_payload[7:0];
`endif

  always_comb begin
    w_byte = HEADER;
    case (r_idx)
      3'd0:    w_byte = HEADER;
      3'd1:    w_byte = {7'd0, r_id};
      3'd2:    w_byte = r_payload[31:24];
      3'd3:    w_byte = r_payload[23:16];
      3'd4:    w_byte = r_payload[15:8];
      3'd5:    w_byte = r_payload[7:0];
`ifdef UART_FRAME_CHKSUM_EN
      3'd6:    w_byte = w_chksum;
`endif
      default: w_byte = HEADER;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_cnt        <= 20'd0;
      r_last_grant <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_flag       <= 1'b0;
      r_pi_data    <= 8'd0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_flag <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (w_gnt_vld) begin
            r_busy       <= 1'b1;
            r_ack0       <= ~w_gnt_ch;
            r_ack1       <= w_gnt_ch;
            r_last_grant <= w_gnt_ch;
            r_idx        <= 3'd0;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          r_pi_data <= w_byte;
          r_flag    <= 1'b1;
          r_cnt     <= 20'd0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if ((r_idx == LAST_IDX) && (r_cnt == END_TC)) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if ((r_idx != LAST_IDX) && (r_cnt == GAP_TC)) begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload and ID are captured only at grant; later changes on data0/data1 are ignored.
  always_ff @(posedge sys_clk) begin
    if ((r_state == S_IDLE) && w_gnt_vld) begin
      r_id      <= w_gnt_ch;
      r_payload <= w_gnt_ch ? data1 : data0;
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched: one instance at 115200 baud, one fast-paced instance for multi-frame scenarios.
module tb_uart_frame_sched;

  localparam int BP_A = 4774;
  localparam int BP_B = 110;
`ifdef UART_FRAME_CHKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  logic        a_req0, a_req1, a_ack0, a_ack1, a_busy, a_done, a_pf;
  logic [31:0] a_data0, a_data1;
  logic [7:0]  a_pd;
  logic        b_req0, b_req1, b_ack0, b_ack1, b_busy, b_done, b_pf;
  logic [31:0] b_data0, b_data1;
  logic [7:0]  b_pd;

  uart_frame_sched #(.UART_BPS(115200), .CLK_FREQ(50_000_000)) u_dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0(a_req0), .data0(a_data0), .ack0(a_ack0),
    .req1(a_req1), .data1(a_data1), .ack1(a_ack1),
    .busy(a_busy), .frame_done(a_done), .pi_data(a_pd), .pi_flag(a_pf));

  uart_frame_sched #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000)) u_dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
    .req1(b_req1), .data1(b_data1), .ack1(b_ack1),
    .busy(b_busy), .frame_done(b_done), .pi_data(b_pd), .pi_flag(b_pf));

  int         a_ft[$], a_dt[$], a_a0t[$], a_a1t[$];
  logic [7:0] a_fd[$];
  int         b_ft[$], b_dt[$], b_a0t[$], b_a1t[$];
  logic [7:0] b_fd[$];
  int         a_stab = 0, b_stab = 0;
  logic [7:0] a_hold = 8'h00, b_hold = 8'h00;

  // Event recorder: strobe times/bytes, acks, frame_done, and pi_data changes outside a strobe.
  initial forever begin
    @(negedge clk);
    if (a_pf) begin a_ft.push_back(cyc); a_fd.push_back(a_pd); end
    if (a_done) a_dt.push_back(cyc);
    if (a_ack0) a_a0t.push_back(cyc);
    if (a_ack1) a_a1t.push_back(cyc);
    if (b_pf) begin b_ft.push_back(cyc); b_fd.push_back(b_pd); end
    if (b_done) b_dt.push_back(cyc);
    if (b_ack0) b_a0t.push_back(cyc);
    if (b_ack1) b_a1t.push_back(cyc);
    if (!rst_n) begin a_hold = 8'h00; b_hold = 8'h00; end
    else begin
      if (a_pf) a_hold = a_pd; else if (a_pd !== a_hold) a_stab++;
      if (b_pf) b_hold = b_pd; else if (b_pd !== b_hold) b_stab++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic evt(input int sel);
    case (sel)
      0:       return a_ack0 | a_ack1;
      1:       return a_done;
      2:       return b_ack0 | b_ack1;
      default: return b_done;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input int lim, input string tag);
    int n = 0;
    @(negedge clk);
    while (!evt(sel) && n < lim) begin @(negedge clk); n++; end
    #1;
    chk(tag, 64'(evt(sel)), 64'(1));
  endtask

  task automatic chk_frame_b(input int base, input logic id, input logic [31:0] p, input string tag);
    logic [7:0] e[7];
    e[0] = 8'hA5;
    e[1] = {7'd0, id};
    e[2] = p[31:24];
    e[3] = p[23:16];
    e[4] = p[15:8];
    e[5] = p[7:0];
    e[6] = e[1] + e[2] + e[3] + e[4] + e[5];
    for (int i = 0; i < NB; i++)
      chk($sformatf("%s_byte%0d", tag, i), 64'(b_fd[base+i]), 64'(e[i]));
    for (int i = 1; i < NB; i++)
      chk($sformatf("%s_gap%0d", tag, i), 64'(b_ft[base+i] - b_ft[base+i-1]), 64'(BP_B));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_a[7];
    int fb, fb2, n;
    exp_a[0] = 8'hA5; exp_a[1] = 8'h00; exp_a[2] = 8'h12; exp_a[3] = 8'h34;
    exp_a[4] = 8'h56; exp_a[5] = 8'h78; exp_a[6] = 8'h14;
    a_req0 = 1'b0; a_req1 = 1'b0; a_data0 = 32'h0; a_data1 = 32'h0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_data0 = 32'h0; b_data1 = 32'h0;

    repeat (3) @(negedge clk);
    chk("a_reset_outs", 64'({a_busy, a_done, a_ack0, a_ack1, a_pf, a_pd}), 64'(0));
    chk("b_reset_outs", 64'({b_busy, b_done, b_ack0, b_ack1, b_pf, b_pd}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single request at 115200 baud, data0 changed after ack
    a_data0 = 32'h12345678; a_req0 = 1'b1;
    wait_evt(0, 20, "a_ack_seen");
    chk("a_ack_is_ch0", 64'({a_ack0, a_ack1}), 64'(2'b10));
    a_req0 = 1'b0; a_data0 = 32'hDEADBEEF;
    wait_evt(1, 8 * BP_A, "a_frame_done_seen");
    chk("a_busy_at_done", 64'(a_busy), 64'(1));
    chk("a_ack0_count", 64'(a_a0t.size()), 64'(1));
    chk("a_ack1_count", 64'(a_a1t.size()), 64'(0));
    chk("a_flag_count", 64'(a_ft.size()), 64'(NB));
    chk("a_ack_to_flag", 64'(a_ft[0] - a_a0t[0]), 64'(1));
    for (int i = 0; i < NB; i++) chk($sformatf("a_byte%0d", i), 64'(a_fd[i]), 64'(exp_a[i]));
    for (int i = 1; i < NB; i++) chk($sformatf("a_gap%0d", i), 64'(a_ft[i] - a_ft[i-1]), 64'(BP_A));
    chk("a_done_after_last_flag", 64'(a_dt[0] - a_ft[NB-1]), 64'(BP_A));
    chk("a_data_stable", 64'(a_stab), 64'(0));
    @(negedge clk);
    chk("a_busy_after_done", 64'(a_busy), 64'(0));
    chk("a_pi_data_held", 64'(a_pd), 64'(exp_a[NB-1]));

    // Contention right after reset: ch0 first, ch1 granted the cycle after frame_done
    b_data0 = 32'hA0A1A2A3; b_data1 = 32'hB0B1B2B3; b_req0 = 1'b1; b_req1 = 1'b1;
    wait_evt(2, 20, "b_c1_ack_seen");
    chk("b_contend_first_ch0", 64'({b_ack0, b_ack1}), 64'(2'b10));
    b_req0 = 1'b0;
    wait_evt(3, 8 * BP_B, "b_c1_done_seen");
    wait_evt(2, 20, "b_c2_ack_seen");
    chk("b_contend_second_ch1", 64'({b_ack0, b_ack1}), 64'(2'b01));
    chk("b_c2_ack_after_done", 64'(b_a1t[0] - b_dt[0]), 64'(1));
    b_req1 = 1'b0;
    wait_evt(3, 8 * BP_B, "b_c2_done_seen");
    chk_frame_b(0, 1'b0, 32'hA0A1A2A3, "b_c1");
    chk_frame_b(NB, 1'b1, 32'hB0B1B2B3, "b_c2");
    chk("b_c2_flag_after_done", 64'(b_ft[NB] - b_dt[0]), 64'(2));

    // Both held high: grants alternate 0,1,0,1
    b_req0 = 1'b1; b_req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_evt(2, 20, $sformatf("b_alt%0d_ack_seen", k));
      chk($sformatf("b_alt%0d_grant", k), 64'(b_ack1), 64'(k % 2));
      if (k == 3) begin b_req0 = 1'b0; b_req1 = 1'b0; end
      wait_evt(3, 8 * BP_B, $sformatf("b_alt%0d_done_seen", k));
    end

    // Request while busy stays pending until after frame_done
    fb = b_ft.size();
    b_data0 = 32'h0F1E2D3C; b_req0 = 1'b1;
    wait_evt(2, 20, "b_busy_ack0_seen");
    b_req0 = 1'b0;
    repeat (3 * BP_B) @(negedge clk);
    b_data1 = 32'h5A5AC3C3; b_req1 = 1'b1;
    n = b_a1t.size();
    wait_evt(3, 8 * BP_B, "b_busy_done_seen");
    chk("b_no_ack1_while_busy", 64'(b_a1t.size()), 64'(n));
    wait_evt(2, 20, "b_busy_ack1_seen");
    chk("b_busy_ack1_after_done", 64'(b_a1t[b_a1t.size()-1] - b_dt[b_dt.size()-1]), 64'(1));
    b_req1 = 1'b0;
    wait_evt(3, 8 * BP_B, "b_busy_done2_seen");
    chk_frame_b(fb, 1'b0, 32'h0F1E2D3C, "b_bz1");
    chk_frame_b(fb + NB, 1'b1, 32'h5A5AC3C3, "b_bz2");

    // Reset during byte 3 aborts the frame; a fresh request starts over at HEADER
    b_data0 = 32'h11223344; b_req0 = 1'b1;
    wait_evt(2, 20, "b_rst_ack_seen");
    b_req0 = 1'b0;
    fb = b_ft.size();
    n = 0;
    while (b_ft.size() < fb + 3 && n < 4 * BP_B) begin @(negedge clk); n++; end
    chk("b_rst_third_byte_seen", 64'(b_ft.size()), 64'(fb + 3));
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("b_async_reset_outs", 64'({b_busy, b_done, b_ack0, b_ack1, b_pf, b_pd}), 64'(0));
    chk("a_async_reset_outs", 64'({a_busy, a_done, a_ack0, a_ack1, a_pf, a_pd}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b_data0 = 32'h55667788; b_req0 = 1'b1;
    fb2 = b_ft.size();
    chk("b_rst_no_resume", 64'(fb2), 64'(fb + 3));
    wait_evt(2, 20, "b_rst_new_ack_seen");
    b_req0 = 1'b0;
    wait_evt(3, 8 * BP_B, "b_rst_new_done_seen");
    chk("b_rst_new_flag_count", 64'(b_ft.size() - fb2), 64'(NB));
    chk_frame_b(fb2, 1'b0, 32'h55667788, "b_rnew");

    // All-ones payload on ch1 (checksum wraps to FD when enabled)
    fb = b_ft.size();
    b_data1 = 32'hFFFFFFFF; b_req1 = 1'b1;
    wait_evt(2, 20, "b_ff_ack_seen");
    chk("b_ff_ack_is_ch1", 64'({b_ack0, b_ack1}), 64'(2'b01));
    b_req1 = 1'b0;
    wait_evt(3, 8 * BP_B, "b_ff_done_seen");
    chk_frame_b(fb, 1'b1, 32'hFFFFFFFF, "b_ff");
`ifdef UART_FRAME_CHKSUM_EN
    chk("b_chksum_wrap", 64'(b_fd[fb+6]), 64'(8'hFD));
`endif
    chk("b_data_stable", 64'(b_stab), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
